// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-time controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef logic [3:0]  bcd_t;
  typedef logic [15:0] mmss_t;

  localparam mmss_t      MMSS_ZERO   = 16'h0000;
  localparam logic [7:0] SEC_MAX_BCD = 8'h59;

  function automatic logic digit_ok(input bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement; saturates at 00:00, flags 00:01.
module bcd_mmss_dec
  import microwave_pkg::*;
(
  input  mmss_t cur_i,
  output mmss_t nxt_o,
  output logic  is_one_o
);

  always_comb begin
    nxt_o    = cur_i;
    is_one_o = (cur_i == 16'h0001);
    if (cur_i != MMSS_ZERO) begin
      if (cur_i[3:0] != 4'd0) begin
        nxt_o[3:0] = cur_i[3:0] - 4'd1;
      end else begin
        nxt_o[3:0] = 4'd9;
        if (cur_i[7:4] != 4'd0) begin
          nxt_o[7:4] = cur_i[7:4] - 4'd1;
        end else begin
          // SS was 00: wrap to 59 and borrow a minute
          nxt_o[7:4] = 4'd5;
          if (cur_i[11:8] != 4'd0) begin
            nxt_o[11:8] = cur_i[11:8] - 4'd1;
          end else begin
            nxt_o[11:8]  = 4'd9;
            nxt_o[15:12] = cur_i[15:12] - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time FSM: keypad entry, 1 Hz countdown, magnetron and display select.
// Optional completion beep counter enabled by defining MICROWAVE_BEEP_EN.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int QUICK_SECS = 30,
  parameter int BEEP_SECS  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_1hz_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_digit_i,
  input  logic        start_i,
  input  logic        stop_clear_i,
  input  logic        door_open_i,
  output logic        mag_on_o,
  output logic        disp_sel_o,
  output logic [15:0] entry_bcd_o,
  output logic [15:0] count_bcd_o,
  output logic        done_o,
  output logic        beep_o
);

  localparam mmss_t QUICK_MMSS = {8'h00, 4'(QUICK_SECS / 10), 4'(QUICK_SECS % 10)};

  state_e state_q, state_d;
  mmss_t  entry_q, entry_d;
  mmss_t  count_q, count_d;
  mmss_t  dec_nxt, load_val, entry_shift;
  logic   dec_is_one, key_ok, start_ok;

  bcd_mmss_dec u_dec (
    .cur_i    (count_q),
    .nxt_o    (dec_nxt),
    .is_one_o (dec_is_one)
  );

  always_comb begin
    key_ok      = key_valid_i && digit_ok(key_digit_i);
    start_ok    = start_i && !door_open_i;
    entry_shift = {entry_q[11:0], key_digit_i};
    load_val    = entry_q;
    if (entry_q == MMSS_ZERO)        load_val = QUICK_MMSS;
    else if (entry_q[7:4] > 4'd5)    load_val[7:0] = SEC_MAX_BCD;
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE, S_ENTRY, S_DONE: begin
        if (stop_clear_i) begin
          if (state_q == S_ENTRY) entry_d = MMSS_ZERO;
          if (state_q != S_IDLE)  state_d = S_IDLE;
        end else if (start_ok) begin
          count_d = load_val;
          state_d = S_COOK;
        end else if (key_ok) begin
          entry_d = entry_shift;
          if (state_q == S_DONE) count_d = MMSS_ZERO;
          state_d = S_ENTRY;
        end
      end
      S_COOK: begin
        if (stop_clear_i || door_open_i) begin
          state_d = S_PAUSE;
        end else if (tick_1hz_i) begin
          count_d = dec_nxt;
          if (dec_is_one) state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (stop_clear_i) begin
          entry_d = MMSS_ZERO;
          count_d = MMSS_ZERO;
          state_d = S_IDLE;
        end else if (start_ok) begin
          state_d = S_COOK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      entry_q <= MMSS_ZERO;
      count_q <= MMSS_ZERO;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

`ifdef MICROWAVE_BEEP_EN
  localparam int BW = $clog2(BEEP_SECS + 1);
  logic          beep_q, beep_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    beep_d = beep_q;
    bcnt_d = bcnt_q;
    if (state_d != S_DONE) begin
      beep_d = 1'b0;
      bcnt_d = '0;
    end else if (state_q != S_DONE) begin
      beep_d = 1'b1;
      bcnt_d = BW'(BEEP_SECS);
    end else if (tick_1hz_i && beep_q) begin
      bcnt_d = bcnt_q - 1'b1;
      if (bcnt_q == BW'(1)) beep_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beep_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      beep_q <= beep_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign beep_o = beep_q;
`else
  assign beep_o = 1'b0;
`endif

  assign mag_on_o    = (state_q == S_COOK) && !door_open_i;
  assign disp_sel_o  = (state_q == S_COOK) || (state_q == S_PAUSE) || (state_q == S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign entry_bcd_o = entry_q;
  assign count_bcd_o = count_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed self-checking bench for microwave_timer_ctrl (beep checks follow MICROWAVE_BEEP_EN).
module tb_microwave_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, key_valid, start, stop_clear, door_open;
  logic [3:0]  key_digit;
  logic        mag_on, disp_sel, done, beep;
  logic [15:0] entry_bcd, count_bcd;
  int          n_chk = 0;
  int          n_err = 0;

  microwave_timer_ctrl #(.QUICK_SECS(30), .BEEP_SECS(3)) dut (
    .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick), .key_valid_i(key_valid),
    .key_digit_i(key_digit), .start_i(start), .stop_clear_i(stop_clear),
    .door_open_i(door_open), .mag_on_o(mag_on), .disp_sel_o(disp_sel),
    .entry_bcd_o(entry_bcd), .count_bcd_o(count_bcd), .done_o(done), .beep_o(beep)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_digit = d; key_valid = 1'b1; cyc(); key_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop_clear = 1'b1; cyc(); stop_clear = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic clear_all();
    do_stop(); do_stop(); do_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 0; key_valid = 0; key_digit = 0; start = 0; stop_clear = 0; door_open = 0;
    cyc(); cyc(); rst = 1'b0;
    n_chk++; if ({mag_on, disp_sel, done, beep} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {mag_on, disp_sel, done, beep}); end
    n_chk++; if ({entry_bcd, count_bcd} !== 32'h0) begin n_err++; $display("FAIL reset_regs got=%h exp=00000000", {entry_bcd, count_bcd}); end
  endtask

  task automatic test_entry_cook();
    press(1); press(3); press(0);
    n_chk++; if (entry_bcd !== 16'h0130) begin n_err++; $display("FAIL t1_entry got=%h exp=0130", entry_bcd); end
    do_start();
    n_chk++; if (count_bcd !== 16'h0130 || disp_sel !== 1'b1 || mag_on !== 1'b1) begin n_err++; $display("FAIL t1_cook cnt=%h ds=%b mag=%b exp 0130/1/1", count_bcd, disp_sel, mag_on); end
    do_tick();
    n_chk++; if (count_bcd !== 16'h0129) begin n_err++; $display("FAIL t1_tick1 got=%h exp=0129", count_bcd); end
    do_tick();
    n_chk++; if (count_bcd !== 16'h0128) begin n_err++; $display("FAIL t1_tick2 got=%h exp=0128", count_bcd); end
    n_chk++; if (entry_bcd !== 16'h0130) begin n_err++; $display("FAIL t1_entry_kept got=%h exp=0130", entry_bcd); end
    clear_all();
  endtask

  task automatic test_shift();
    press(1); press(2); press(3); press(4); press(5);
    n_chk++; if (entry_bcd !== 16'h2345) begin n_err++; $display("FAIL shift_m10_drop got=%h exp=2345", entry_bcd); end
    clear_all();
  endtask

  task automatic test_done();
    press(1); press(0); press(0); do_start(); do_tick();
    n_chk++; if (count_bcd !== 16'h0059) begin n_err++; $display("FAIL t2_min_borrow got=%h exp=0059", count_bcd); end
    clear_all();
    press(1); press(0); press(0); press(0); do_start(); do_tick();
    n_chk++; if (count_bcd !== 16'h0959) begin n_err++; $display("FAIL t2_m10_borrow got=%h exp=0959", count_bcd); end
    clear_all();
    press(1); do_start(); do_tick();
    n_chk++; if (count_bcd !== 16'h0000 || done !== 1'b1 || mag_on !== 1'b0 || disp_sel !== 1'b1) begin n_err++; $display("FAIL t2_done cnt=%h done=%b mag=%b ds=%b exp 0000/1/0/1", count_bcd, done, mag_on, disp_sel); end
`ifdef MICROWAVE_BEEP_EN
    n_chk++; if (beep !== 1'b1) begin n_err++; $display("FAIL t2_beep_rise got=%b exp=1", beep); end
    do_tick(); do_tick();
    n_chk++; if (beep !== 1'b1) begin n_err++; $display("FAIL t2_beep_hold got=%b exp=1", beep); end
    do_tick();
    n_chk++; if (beep !== 1'b0) begin n_err++; $display("FAIL t2_beep_fall got=%b exp=0", beep); end
`else
    do_tick(); do_tick(); do_tick();
    n_chk++; if (beep !== 1'b0) begin n_err++; $display("FAIL t2_beep_off got=%b exp=0", beep); end
`endif
    n_chk++; if (count_bcd !== 16'h0000 || done !== 1'b1) begin n_err++; $display("FAIL t2_no_underflow cnt=%h done=%b exp 0000/1", count_bcd, done); end
    press(5);
    n_chk++; if (entry_bcd !== 16'h0015 || count_bcd !== 16'h0000 || done !== 1'b0 || disp_sel !== 1'b0) begin n_err++; $display("FAIL t2_key_in_done e=%h c=%h done=%b ds=%b exp 0015/0000/0/0", entry_bcd, count_bcd, done, disp_sel); end
    clear_all();
  endtask

  task automatic test_door();
    press(4); press(5); do_start();
    door_open = 1'b1; tick = 1'b1; #1;
    n_chk++; if (mag_on !== 1'b0) begin n_err++; $display("FAIL t3_mag_same_cycle got=%b exp=0", mag_on); end
    @(posedge clk); #1; tick = 1'b0;
    n_chk++; if (count_bcd !== 16'h0045 || disp_sel !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL t3_pause cnt=%h ds=%b exp 0045/1", count_bcd, disp_sel); end
    do_tick(); do_tick(); do_start();
    door_open = 1'b0; #1;
    n_chk++; if (count_bcd !== 16'h0045 || mag_on !== 1'b0) begin n_err++; $display("FAIL t3_held cnt=%h mag=%b exp 0045/0", count_bcd, mag_on); end
    cyc(); do_start();
    n_chk++; if (mag_on !== 1'b1 || count_bcd !== 16'h0045) begin n_err++; $display("FAIL t3_resume mag=%b cnt=%h exp 1/0045", mag_on, count_bcd); end
    do_tick();
    n_chk++; if (count_bcd !== 16'h0044) begin n_err++; $display("FAIL t3_tick got=%h exp=0044", count_bcd); end
    clear_all();
  endtask

  task automatic test_quick();
    do_start();
    n_chk++; if (count_bcd !== 16'h0030 || mag_on !== 1'b1) begin n_err++; $display("FAIL t4_quick cnt=%h mag=%b exp 0030/1", count_bcd, mag_on); end
    clear_all();
    press(7); press(5); do_start();
    n_chk++; if (count_bcd !== 16'h0059 || entry_bcd !== 16'h0075) begin n_err++; $display("FAIL t4_clamp cnt=%h e=%h exp 0059/0075", count_bcd, entry_bcd); end
    clear_all();
  endtask

  task automatic test_stop_start();
    press(2); do_start();
    stop_clear = 1'b1; start = 1'b1; cyc(); stop_clear = 1'b0; start = 1'b0;
    n_chk++; if (mag_on !== 1'b0 || disp_sel !== 1'b1 || count_bcd !== 16'h0002) begin n_err++; $display("FAIL t5_pause mag=%b ds=%b cnt=%h exp 0/1/0002", mag_on, disp_sel, count_bcd); end
    do_stop();
    n_chk++; if (entry_bcd !== 16'h0 || count_bcd !== 16'h0 || disp_sel !== 1'b0) begin n_err++; $display("FAIL t5_idle e=%h c=%h ds=%b exp 0000/0000/0", entry_bcd, count_bcd, disp_sel); end
  endtask

  task automatic test_rst_cook();
    press(9); do_start(); do_tick();
    rst = 1'b1; cyc(); rst = 1'b0;
    n_chk++; if ({mag_on, disp_sel, done, beep} !== 4'b0000 || entry_bcd !== 16'h0 || count_bcd !== 16'h0) begin n_err++; $display("FAIL t6_rst flags=%b e=%h c=%h exp 0000/0000/0000", {mag_on, disp_sel, done, beep}, entry_bcd, count_bcd); end
    press(4'd12); do_tick();
    n_chk++; if (entry_bcd !== 16'h0 || disp_sel !== 1'b0 || count_bcd !== 16'h0) begin n_err++; $display("FAIL t6_bad_key e=%h ds=%b c=%h exp 0000/0/0000", entry_bcd, disp_sel, count_bcd); end
  endtask

  initial begin
    test_reset();
    test_entry_cook();
    test_shift();
    test_done();
    test_door();
    test_quick();
    test_stop_start();
    test_rst_cook();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
